// File: rtl/counter.sv
// Modulo-M enable-gated counter with combinational carry-out.
// Used as a clock-enable / tick generator for slow timebases.
`timescale 1ns/1ps
module counter #(
  parameter int unsigned M = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic co
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] TC = W'(M - 1);

  logic [W-1:0] cnt;
  logic         tc;

  assign tc = (cnt == TC);

  // For M=1 tc is always true, so cnt stays at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

  assign co = rst_n & en & tc;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter at M = 1, 2, 62 and 100000000.
// Outputs are checked #1 after the falling edge where inputs change.
`timescale 1ns/1ps
module tb_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic co1, co2, co62, cobig;

  int     checks = 0;
  int     errors = 0;
  longint n      = 0;
  int     hits   = 0;
  int     first  = 0;

  always #50 clk = ~clk;

  counter #(.M(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .co(co1)
  );
  counter #(.M(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .co(co2)
  );
  counter #(.M(62)) u62 (
    .clk(clk), .rst_n(rst_n), .en(en), .co(co62)
  );
  counter #(.M(100000000)) ubig (
    .clk(clk), .rst_n(rst_n), .en(en), .co(cobig)
  );

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // n = enabled edges since reset release
  task automatic chk_all();
    logic on;
    on = rst_n & en;
    chk("co_m1", co1, on);
    chk("co_m2", co2, on & logic'(n % 2 == 1));
    chk("co_m62", co62, on & logic'(n % 62 == 61));
    chk("co_mbig", cobig, on & logic'(n == 99999999));
  endtask

  // Entered at a falling edge; leaves at the next falling edge.
  task automatic cyc(input logic e);
    en = e;
    #1;
    chk_all();
    if (co62 === 1'b1) begin
      hits++;
      if (first == 0) first = int'(n) + 1;
    end
    @(posedge clk);
    if (rst_n && en) n++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    #1;
    chk("rst_co_m1", co1, 1'b0);
    chk("rst_co_m2", co2, 1'b0);
    chk("rst_co_m62", co62, 1'b0);
    chk("rst_co_mbig", cobig, 1'b0);

    // Release at 100 ns, free-running for 200 cycles
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    hits = 0;
    first = 0;
    for (int k = 0; k < 200; k++) cyc(1'b1);
    chk("m62_hits_3", logic'(hits == 3), 1'b1);
    chk("m62_first_62", logic'(first == 62), 1'b1);

    // Pseudo-random enable gaps
    for (int k = 0; k < 300; k++)
      cyc(logic'($urandom_range(0, 2) != 0));

    // en drops on terminal count: co follows en, count holds
    for (int k = 0; k < 70 && (n % 62 != 61); k++)
      cyc(1'b1);
    chk("at_tc", logic'(n % 62 == 61), 1'b1);
    en = 1'b1;
    #1;
    chk("tc_co_hi", co62, 1'b1);
    en = 1'b0;
    #1;
    chk("tc_co_drop", co62, 1'b0);
    @(negedge clk);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    chk("tc_held", logic'(u62.cnt == 6'd61), 1'b1);
    cyc(1'b1);
    cyc(1'b1);
    chk("tc_wrapped", logic'(u62.cnt == 6'd1), 1'b1);

    // Asynchronous reset mid-period
    for (int k = 0; k < 70 && (n % 62 != 30); k++)
      cyc(1'b1);
    en = 1'b1;
    #20;
    chk("pre_rst_cnt30", logic'(u62.cnt == 6'd30), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt0", logic'(u62.cnt == 6'd0), 1'b1);
    chk("arst_co62", co62, 1'b0);
    chk("arst_co1", co1, 1'b0);
    chk("arst_co2", co2, 1'b0);
    @(negedge clk);
    chk("arst_hold_cnt0", logic'(u62.cnt == 6'd0), 1'b1);
    rst_n = 1'b1;
    n = 0;
    hits = 0;
    first = 0;
    for (int k = 0; k < 62; k++) cyc(1'b1);
    chk("post_rst_hits_1", logic'(hits == 1), 1'b1);
    chk("post_rst_first_62", logic'(first == 62), 1'b1);

    // M=1 follows en directly
    for (int k = 0; k < 10; k++) cyc(logic'(k % 3 != 0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
